// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue dependency logic:
// default geometry, the 8-byte word offset and the store entry layout.
package lsq_pkg;

  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 44;
  localparam int WORD_OFF   = 3;
  localparam int TAG_W      = ADDR_W_DEF - WORD_OFF;

  // Word tag is sized for the widest supported address; narrower addresses zero-extend.
  typedef struct packed {
    logic             valid;
    logic             resolved;
    logic [TAG_W-1:0] tag;
    logic [7:0]       bmask;
  } lsq_entry_t;

endpackage

// File: rtl/lsq_youngest_pick.sv
// Finds the youngest set entry of a circular match vector, where age is
// measured from the queue head.
module lsq_youngest_pick #(
  parameter int DEPTH = 16
) (
  input  logic [DEPTH-1:0]         match,
  input  logic [$clog2(DEPTH)-1:0] head,
  output logic                     found,
  output logic [$clog2(DEPTH)-1:0] idx
);

  localparam int IDW = $clog2(DEPTH);

  logic [DEPTH-1:0] rot;

  // Rotate so bit a holds the entry of age a; ascending scan leaves the oldest overwritten by the youngest.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    rot   = '0;
    for (int a = 0; a < DEPTH; a++) begin
      rot[a] = match[IDW'(head + IDW'(a))];
    end
    for (int a = 0; a < DEPTH; a++) begin
      if (rot[a]) begin
        found = 1'b1;
        idx   = IDW'(head + IDW'(a));
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fun_lsq_dep.sv
// Store-to-load dependency unit: circular store queue plus NPORT registered
// lookups reporting the youngest older overlapping store and unknown older stores.
module fun_lsq_dep
  import lsq_pkg::*;
#(
  parameter int NPORT  = 3,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int IDW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall,
  input  logic                    except,
  input  logic                    alloc_en,
  output logic [IDW:0]            alloc_ptr,
  output logic                    full,
  output logic                    do_stall,
  input  logic                    st_wr_en,
  input  logic [IDW-1:0]          st_wr_id,
  input  logic [ADDR_W-1:0]       st_wr_addr,
  input  logic [7:0]              st_wr_bmask,
  input  logic                    retire_en,
  input  logic [NPORT-1:0]        p_en,
  input  logic [NPORT*(IDW+1)-1:0] p_lsq,
  input  logic [NPORT*ADDR_W-1:0] p_addr,
  input  logic [NPORT*8-1:0]      p_bmask,
  output logic [NPORT-1:0]        has_dep,
  output logic [NPORT*IDW-1:0]    which_dep,
  output logic [NPORT-1:0]        unk_dep
);

  localparam int PW = IDW + 1;

  function automatic logic [TAG_W-1:0] to_tag(input logic [ADDR_W-1:0] a);
    return TAG_W'(a[ADDR_W-1:WORD_OFF]);
  endfunction

  lsq_entry_t       entries [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    count;
  logic             empty;
  logic             alloc_ok;
  logic             retire_ok;

  logic [NPORT-1:0] found_v;
  logic [NPORT-1:0] unk_v;
  logic [IDW-1:0]   idx_v [NPORT];

  assign count     = tail - head;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (head == tail);
  assign alloc_ptr = tail;
  assign do_stall  = full & alloc_en;
  assign alloc_ok  = alloc_en & ~full;
  assign retire_ok = retire_en & ~empty;

  // Queue state; write, alloc and retire never collide on one index with pre-update full/empty.
  always_ff @(posedge clk) begin
    if (rst || except) begin
      head <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (st_wr_en && entries[st_wr_id].valid) begin
        entries[st_wr_id].resolved <= 1'b1;
        entries[st_wr_id].tag      <= to_tag(st_wr_addr);
        entries[st_wr_id].bmask    <= st_wr_bmask;
      end
      if (alloc_ok) begin
        entries[tail[IDW-1:0]].valid    <= 1'b1;
        entries[tail[IDW-1:0]].resolved <= 1'b0;
        tail <= tail + PW'(1);
      end
      if (retire_ok) begin
        entries[head[IDW-1:0]] <= '0;
        head <= head + PW'(1);
      end
    end
  end

  for (genvar k = 0; k < NPORT; k++) begin : g_port
    logic [PW-1:0]    age_lim;
    logic [TAG_W-1:0] ltag;
    logic [7:0]       lmask;
    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] unres;
    logic             found;
    logic [IDW-1:0]   idx;

    // Wrap bit in the subtraction makes p_lsq == head an empty window rather than a full one.
    assign age_lim = p_lsq[k*PW +: PW] - head;
    assign ltag    = to_tag(p_addr[k*ADDR_W +: ADDR_W]);
    assign lmask   = p_bmask[k*8 +: 8];

    // Age window and overlap compare per entry.
    always_comb begin
      cand  = '0;
      match = '0;
      unres = '0;
      for (int i = 0; i < DEPTH; i++) begin
        cand[i]  = entries[i].valid &&
                   ({1'b0, IDW'(IDW'(i) - head[IDW-1:0])} < age_lim);
        match[i] = cand[i] && entries[i].resolved && (entries[i].tag == ltag) &&
                   ((entries[i].bmask & lmask) != 8'h00);
        unres[i] = cand[i] && !entries[i].resolved;
      end
    end

    lsq_youngest_pick #(.DEPTH(DEPTH)) u_pick (
      .match (match),
      .head  (head[IDW-1:0]),
      .found (found),
      .idx   (idx)
    );

    assign found_v[k] = found;
    assign unk_v[k]   = |unres;
    assign idx_v[k]   = idx;
  end

  // Registered lookup results; stall holds them, a disabled port clears.
  always_ff @(posedge clk) begin
    if (rst || except) begin
      has_dep   <= '0;
      unk_dep   <= '0;
      which_dep <= '0;
    end else if (!stall) begin
      has_dep <= p_en & found_v;
      unk_dep <= p_en & unk_v;
      for (int k = 0; k < NPORT; k++) begin
        which_dep[k*IDW +: IDW] <= (p_en[k] && found_v[k]) ? idx_v[k] : '0;
      end
    end else begin
      has_dep   <= has_dep;
      unk_dep   <= unk_dep;
      which_dep <= which_dep;
    end
  end

endmodule
